// File: rtl/pipe_trace_buffer_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// pipe_trace_buffer_pkg : trigger-mode and FSM state encodings
// rev 1.0
// ------------------------------------------------------------------
package pipe_trace_buffer_pkg;

  localparam logic [1:0] TM_START   = 2'b00;
  localparam logic [1:0] TM_CENTER  = 2'b01;
  localparam logic [1:0] TM_QUALIFY = 2'b10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_POST  = 3'd2;
  localparam logic [2:0] ST_FETCH = 3'd3;
  localparam logic [2:0] ST_SHOW  = 3'd4;

  // Encoding 11 is an alias of START.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? TM_START : m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_trace_buffer_trace_ram.sv
`default_nettype none
// ------------------------------------------------------------------
// trace_ram : DEPTH x DATA_W, one write port, one registered read port
// rev 1.0
// ------------------------------------------------------------------
module trace_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/pipe_trace_buffer.sv
`default_nettype none
// ------------------------------------------------------------------
// pipe_trace_buffer : triggered ring capture of pipeline snapshots,
// streamed out oldest-first over valid/ready.            rev 1.0
// ------------------------------------------------------------------
module pipe_trace_buffer
  import pipe_trace_buffer_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic [1:0]        trig_mode,
  input  logic [ADDR_W-1:0] post_count,
  input  logic              trigger,
  input  logic              cap_valid,
  input  logic [DATA_W-1:0] cap_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic [ADDR_W-1:0] trig_pos,
  output logic              wrapped,
  output logic              busy
);

  localparam logic [ADDR_W:0]   CNT_MAX  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W+1)'(DEPTH-1);
  localparam logic [ADDR_W-1:0] REM_FULL = ADDR_W'(DEPTH-1);

  logic [2:0]        state, state_nx;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] post_lim, remaining, wr_ptr, trig_addr;
  logic [ADDR_W-1:0] start_ptr, rd_addr;
  logic [ADDR_W:0]   count, entries_read;
  logic              wr_en, trig_hit;
  logic [DATA_W-1:0] ram_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state and write-accept decode
  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    trig_hit = 1'b0;
    if (arm) begin
      state_nx = ST_ARMED;
    end else begin
      case (state)
        ST_ARMED: begin
          case (mode)
            TM_CENTER: begin
              wr_en = cap_valid;
              if (cap_valid && trigger) begin
                trig_hit = 1'b1;
                state_nx = (post_lim == '0) ? ST_FETCH : ST_POST;
              end
            end
            TM_QUALIFY: begin
              wr_en = cap_valid && trigger;
              if (wr_en && count == CNT_LAST) state_nx = ST_FETCH;
            end
            default: begin
              wr_en    = cap_valid && trigger;
              trig_hit = wr_en;
              if (wr_en) state_nx = ST_POST;
            end
          endcase
        end
        ST_POST: begin
          wr_en = cap_valid;
          if (cap_valid && remaining == ADDR_W'(1)) state_nx = ST_FETCH;
        end
        ST_FETCH: state_nx = ST_SHOW;
        ST_SHOW:  if (rd_ready) state_nx = rd_last ? ST_IDLE : ST_FETCH;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  // Pointers, counters and capture bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      mode         <= TM_START;
      post_lim     <= '0;
      remaining    <= '0;
      wr_ptr       <= '0;
      trig_addr    <= '0;
      count        <= '0;
      entries_read <= '0;
      wrapped      <= 1'b0;
    end else if (arm) begin
      // post_count is ADDR_W wide, so it can never exceed DEPTH-1.
      mode         <= norm_mode(trig_mode);
      post_lim     <= post_count;
      remaining    <= '0;
      wr_ptr       <= '0;
      trig_addr    <= '0;
      count        <= '0;
      entries_read <= '0;
      wrapped      <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (count == CNT_MAX) wrapped <= 1'b1;
        else                  count   <= count + 1'b1;
      end
      if (trig_hit) begin
        trig_addr <= wr_ptr;
        remaining <= (mode == TM_CENTER) ? post_lim : REM_FULL;
      end else if (state == ST_POST && wr_en) begin
        remaining <= remaining - 1'b1;
      end
      if (state == ST_SHOW && rd_ready) entries_read <= entries_read + 1'b1;
    end
  end

  // After the stop, wr_ptr points at the oldest entry once the ring has wrapped.
  assign start_ptr = wrapped ? wr_ptr : '0;
  assign rd_addr   = start_ptr + entries_read[ADDR_W-1:0];

  trace_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (cap_data),
    .re    (state == ST_FETCH),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  // Output decode
  always_comb begin
    busy     = (state != ST_IDLE);
    rd_valid = (state == ST_SHOW);
    rd_last  = rd_valid && (entries_read == count - 1'b1);
    rd_data  = rd_valid ? ram_q : '0;
    trig_pos = trig_addr - start_ptr;
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_trace_buffer.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_pipe_trace_buffer : randomized capture/readout against a
// sample-list reference model.                            rev 1.0
// ------------------------------------------------------------------
module tb_pipe_trace_buffer;
  import pipe_trace_buffer_pkg::*;

  localparam int DW = 64;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset, arm, trigger, cap_valid, rd_ready;
  logic [1:0]    trig_mode;
  logic [AW-1:0] post_count;
  logic [DW-1:0] cap_data;
  logic          rd_valid, rd_last, wrapped, busy;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] trig_pos;

  int n_vec = 0;
  int n_err = 0;

  pipe_trace_buffer #(.DATA_W(DW), .DEPTH(D), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .trig_mode  (trig_mode),
    .post_count (post_count),
    .trigger    (trigger),
    .cap_valid  (cap_valid),
    .cap_data   (cap_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_last    (rd_last),
    .trig_pos   (trig_pos),
    .wrapped    (wrapped),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  busy,     0);
    check({tag, "_rdv"},   rd_valid, 0);
    check({tag, "_last"},  rd_last,  0);
    check({tag, "_wrap"},  wrapped,  0);
    check({tag, "_tpos"},  trig_pos, 0);
    check({tag, "_rdata"}, rd_data,  0);
  endtask

  // tsel: 0 random trigger, 1 trigger when data==tdata, 2 trigger on even data
  task automatic run_capture(input logic [1:0] m, input logic [AW-1:0] post,
                             input int tsel, input int tdata, input int vprob,
                             input bit arm_in_show);
    logic [63:0] vq[$];
    bit          tq[$];
    logic [63:0] expq[$];
    logic [63:0] ctr = 0;
    logic [63:0] d, held;
    logic [1:0]  mm;
    int t, s, e, etp, n, cyc;
    bit cv, tg, ewr, stalled, rdy;

    @(negedge clk);
    arm = 1; trig_mode = m; post_count = post;
    cap_valid = 0; trigger = 0; rd_ready = 0;
    @(negedge clk);
    arm = 0;
    check("armed_busy", busy, 1);
    check("armed_rdv", rd_valid, 0);

    cyc = 0;
    while (!rd_valid && cyc < 300) begin
      cv = ($urandom_range(99) < vprob);
      d  = ctr;
      ctr++;
      case (tsel)
        0:       tg = ($urandom_range(3) == 0);
        1:       tg = (d == 64'(tdata));
        default: tg = (d[0] == 1'b0);
      endcase
      cap_valid = cv; trigger = tg; cap_data = d;
      if (cv) begin
        vq.push_back(d);
        tq.push_back(tg);
      end
      @(negedge clk);
      cyc++;
    end
    cap_valid = 0; trigger = 0;
    check("stop_reached", rd_valid, 1);

    // Reference: pick the captured window straight from the list of valid samples.
    mm = (m == 2'b11) ? TM_START : m;
    t = -1;
    foreach (tq[i]) if (tq[i] && t < 0) t = i;
    etp = 0; ewr = 0;
    if (mm == TM_QUALIFY) begin
      foreach (vq[i]) if (tq[i] && expq.size() < D) expq.push_back(vq[i]);
    end else if (t >= 0) begin
      e = (mm == TM_CENTER) ? t + int'(post) : t + D - 1;
      s = (e - D + 1 < 0) ? 0 : e - D + 1;
      if (mm == TM_START) s = t;
      for (int i = s; i <= e && i < vq.size(); i++) expq.push_back(vq[i]);
      etp = t - s;
      ewr = (mm == TM_CENTER) && (e + 1 > D);
    end

    if (arm_in_show) begin
      arm = 1;
      @(negedge clk);
      arm = 0;
      check("arm_flush_rdv", rd_valid, 0);
      check("arm_flush_busy", busy, 1);
      check("arm_flush_wrap", wrapped, 0);
      return;
    end

    check("trig_pos", trig_pos, etp);
    check("wrapped", wrapped, ewr);

    n = 0; stalled = 0; held = '0; cyc = 0;
    while (n < expq.size() && cyc < 400) begin
      if (stalled && rd_valid) check("stall_hold", rd_data, held);
      rdy = $urandom_range(1);
      rd_ready = rdy;
      if (rd_valid && rdy) begin
        check("rd_data", rd_data, expq[n]);
        check("rd_last", rd_last, (n == expq.size() - 1));
        n++;
        stalled = 0;
      end else if (rd_valid) begin
        held = rd_data;
        stalled = 1;
      end else begin
        stalled = 0;
      end
      @(negedge clk);
      cyc++;
    end
    rd_ready = 0;
    check("rd_count", n, expq.size());
    check("done_busy", busy, 0);
    check("done_rdv", rd_valid, 0);
  endtask

  initial begin
    reset = 1; arm = 0; trigger = 0; cap_valid = 0; rd_ready = 0;
    trig_mode = 0; post_count = 0; cap_data = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    check_idle_outputs("reset");

    run_capture(TM_START,   3'd0, 1, 16, 100, 0);
    run_capture(TM_CENTER,  3'd2, 1, 10, 100, 0);
    run_capture(TM_CENTER,  3'd1, 1,  3, 100, 0);
    run_capture(TM_QUALIFY, 3'd0, 2,  0, 100, 0);

    for (int k = 0; k < 12; k++)
      run_capture(2'($urandom_range(3)), AW'($urandom_range(D-1)), 0, 0, 60, 0);

    // Reset while in POST
    @(negedge clk);
    arm = 1; trig_mode = TM_START;
    @(negedge clk);
    arm = 0; cap_valid = 1; trigger = 1; cap_data = 64'h55;
    @(negedge clk);
    trigger = 0; cap_data = 64'h56;
    @(negedge clk);
    check("post_busy", busy, 1);
    reset = 1; cap_valid = 0;
    @(negedge clk);
    reset = 0;
    check_idle_outputs("midreset");

    // Arm while showing, then a clean capture with independent trigger/valid
    run_capture(TM_CENTER, 3'd3, 0, 0, 50, 1);
    run_capture(TM_START,  3'd0, 0, 0, 50, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
